bp_be_thread_scheduler: RTL and testbench

BP_BE_THREAD_SCHEDULER -- requirements
Module: bp_be_thread_scheduler

---
 rtl/bp_be_pkg.sv | 11 +
 rtl/bp_be_thread_rr_picker.sv | 31 +++
 rtl/bp_be_thread_scheduler.sv | 159 +++++++++++++++
 tb/tb_bp_be_thread_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_be_pkg.sv
// Backend scheduler shared types: the thread-scheduler state enum.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_sched_idle,
    e_sched_run,
    e_sched_drain,
    e_sched_switch
  } bp_be_sched_state_e;

endpackage

// File: rtl/bp_be_thread_rr_picker.sv
// Combinational round-robin picker: first ready thread in start+1 .. start+N (mod N).
module bp_be_thread_rr_picker #(
  parameter  int num_threads_p = 2,
  localparam int tw            = $clog2(num_threads_p) + 1
) (
  input  logic [num_threads_p-1:0] ready_i,
  input  logic [tw-1:0]            start_i,
  output logic                     v_o,
  output logic [tw-1:0]            tid_o
);

  always_comb begin
    int                       s;
    logic [num_threads_p-1:0] rot;
    v_o   = 1'b0;
    tid_o = '0;
    s     = 0;
    rot   = '0;
    // start_i is always a legal tid, so one conditional subtract replaces the modulo
    for (int i = 1; i <= num_threads_p; i++) begin
      s = int'(start_i) + i;
      if (s >= num_threads_p) s = s - num_threads_p;
      rot = ready_i >> s;
      if (!v_o && rot[0]) begin
        v_o   = 1'b1;
        tid_o = tw'(s);
      end
    end
  end

endmodule

// File: rtl/bp_be_thread_scheduler.sv
// Backend hardware-thread scheduler (IDLE/RUN/DRAIN/SWITCH).
// Define BP_BE_SCHED_TIMESLICE_EN to build the quantum counter and expiry-driven switching.
module bp_be_thread_scheduler
  import bp_be_pkg::*;
#(
  parameter  int num_threads_p = 2,
  parameter  int quantum_p     = 256,
  localparam int tw            = $clog2(num_threads_p) + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [num_threads_p-1:0] thread_ready_i,
  input  logic                     switch_req_v_i,
  input  logic [tw-1:0]            switch_req_tid_i,
  input  logic                     pipe_drained_i,
  output logic                     drain_req_o,
  output logic [tw-1:0]            current_thread_id_o,
  output logic                     switch_v_o,
  output logic                     idle_o
);

  if (num_threads_p < 1 || num_threads_p > 8 || quantum_p < 2) begin : g_bad_param
    $error("bp_be_thread_scheduler: illegal num_threads_p or quantum_p");
  end

  localparam logic [num_threads_p-1:0] lsb_lp = num_threads_p'(1);

  bp_be_sched_state_e state_r, state_n;
  logic [tw-1:0] cur_r, cur_n, last_r, last_n, tgt_r, tgt_n;
  logic          tgt_v_r, tgt_v_n;

  logic [num_threads_p-1:0] others, pick_mask;
  logic [tw-1:0]            pick_start, pick_tid;
  logic                     pick_v, cur_ready, tgt_ready, req_ok;

  function automatic logic bit_at(logic [num_threads_p-1:0] m, logic [tw-1:0] t);
    logic [num_threads_p-1:0] s;
    s = m >> t;
    return s[0];
  endfunction

  assign others    = thread_ready_i & ~(lsb_lp << cur_r);
  assign cur_ready = bit_at(thread_ready_i, cur_r);
  assign tgt_ready = bit_at(thread_ready_i, tgt_r);
  assign req_ok    = switch_req_v_i
                   && (switch_req_tid_i < tw'(num_threads_p))
                   && (switch_req_tid_i != cur_r)
                   && bit_at(thread_ready_i, switch_req_tid_i);

  // From IDLE every ready thread is a candidate; otherwise the running thread is excluded
  assign pick_mask  = (state_r == e_sched_idle) ? thread_ready_i : others;
  assign pick_start = (state_r == e_sched_idle) ? last_r : cur_r;

  bp_be_thread_rr_picker #(.num_threads_p(num_threads_p)) picker (
    .ready_i (pick_mask),
    .start_i (pick_start),
    .v_o     (pick_v),
    .tid_o   (pick_tid)
  );

`ifdef BP_BE_SCHED_TIMESLICE_EN
  localparam int cw = $clog2(quantum_p);
  logic [cw-1:0] cnt_r, cnt_n;
  logic          expire;
  assign expire = (cnt_r == cw'(quantum_p - 1));
`endif

  always_comb begin
    state_n = state_r;
    cur_n   = cur_r;
    last_n  = last_r;
    tgt_n   = tgt_r;
    tgt_v_n = tgt_v_r;
`ifdef BP_BE_SCHED_TIMESLICE_EN
    cnt_n   = cnt_r;
`endif
    case (state_r)
      e_sched_idle: begin
        if (pick_v) begin
          tgt_n   = pick_tid;
          tgt_v_n = 1'b1;
          state_n = e_sched_switch;
        end
      end
      e_sched_run: begin
`ifdef BP_BE_SCHED_TIMESLICE_EN
        cnt_n = cnt_r + 1'b1;
`endif
        if (req_ok) begin
          tgt_n   = switch_req_tid_i;
          tgt_v_n = 1'b1;
          state_n = e_sched_drain;
        end else if (!cur_ready) begin
          tgt_n   = pick_tid;
          tgt_v_n = pick_v;
          state_n = e_sched_drain;
        end
`ifdef BP_BE_SCHED_TIMESLICE_EN
        else if (expire) begin
          if (pick_v) begin
            tgt_n   = pick_tid;
            tgt_v_n = 1'b1;
            state_n = e_sched_drain;
          end else begin
            cnt_n = '0;
          end
        end
`endif
      end
      e_sched_drain: begin
        // A target that lost readiness is replaced before the drain completes
        if (tgt_v_r && !tgt_ready) begin
          tgt_n   = pick_tid;
          tgt_v_n = pick_v;
        end
        if (pipe_drained_i) state_n = tgt_v_n ? e_sched_switch : e_sched_idle;
      end
      e_sched_switch: begin
        cur_n   = tgt_r;
        last_n  = tgt_r;
        tgt_v_n = 1'b0;
`ifdef BP_BE_SCHED_TIMESLICE_EN
        cnt_n   = '0;
`endif
        state_n = e_sched_run;
      end
      default: state_n = e_sched_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_sched_idle;
      cur_r   <= '0;
      last_r  <= tw'(num_threads_p - 1);
      tgt_r   <= '0;
      tgt_v_r <= 1'b0;
    end else begin
      state_r <= state_n;
      cur_r   <= cur_n;
      last_r  <= last_n;
      tgt_r   <= tgt_n;
      tgt_v_r <= tgt_v_n;
    end
  end

`ifdef BP_BE_SCHED_TIMESLICE_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_r <= '0;
    else         cnt_r <= cnt_n;
  end
`endif

  assign drain_req_o         = (state_r != e_sched_run);
  assign idle_o              = (state_r == e_sched_idle);
  assign switch_v_o          = (state_r == e_sched_switch);
  assign current_thread_id_o = cur_r;

endmodule

// File: tb/tb_bp_be_thread_scheduler.sv
// Bench for bp_be_thread_scheduler: two configurations (2 threads/q=4, 3 threads/q=5)
// against a behavioural scheduler model; honours BP_BE_SCHED_TIMESLICE_EN.
module tb_bp_be_thread_scheduler;

`ifdef BP_BE_SCHED_TIMESLICE_EN
  localparam bit ts_en = 1'b1;
`else
  localparam bit ts_en = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_SWITCH = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] r0 = '0, rt0 = '0, tid0;
  logic       rv0 = 1'b0, dr0 = 1'b0, drq0, sv0, idl0;
  logic [2:0] r1 = '0, rt1 = '0, tid1;
  logic       rv1 = 1'b0, dr1 = 1'b0, drq1, sv1, idl1;

  bp_be_thread_scheduler #(.num_threads_p(2), .quantum_p(4)) dut0 (
    .clk_i(clk), .reset_i(rst), .thread_ready_i(r0), .switch_req_v_i(rv0),
    .switch_req_tid_i(rt0), .pipe_drained_i(dr0), .drain_req_o(drq0),
    .current_thread_id_o(tid0), .switch_v_o(sv0), .idle_o(idl0));

  bp_be_thread_scheduler #(.num_threads_p(3), .quantum_p(5)) dut1 (
    .clk_i(clk), .reset_i(rst), .thread_ready_i(r1), .switch_req_v_i(rv1),
    .switch_req_tid_i(rt1), .pipe_drained_i(dr1), .drain_req_o(drq1),
    .current_thread_id_o(tid1), .switch_v_o(sv1), .idle_o(idl1));

  typedef struct {
    int mode;
    int cur;
    int last;
    int tgt;
    bit has;
    int cnt;
  } mdl_t;

  mdl_t m[2];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr(input int mask, input int from, input int n);
    for (int k = 1; k <= n; k++)
      if (((mask >> ((from + k) % n)) & 1) != 0) return (from + k) % n;
    return -1;
  endfunction

  function automatic mdl_t reset_mdl(input int n);
    mdl_t o;
    o.mode = M_IDLE; o.cur = 0; o.last = n - 1; o.tgt = 0; o.has = 1'b0; o.cnt = 0;
    return o;
  endfunction

  function automatic mdl_t step(input mdl_t s, input int n, input int q, input int rdy,
                                input bit rv, input int rt, input bit dr);
    mdl_t o;
    int   oth, p;
    o   = s;
    oth = rdy & ~(1 << s.cur);
    p   = -1;
    case (s.mode)
      M_IDLE: begin
        p = rr(rdy, s.last, n);
        if (p >= 0) begin o.tgt = p; o.mode = M_SWITCH; end
      end
      M_RUN: begin
        if (rv && rt < n && rt != s.cur && ((rdy >> rt) & 1) != 0) begin
          o.tgt = rt; o.has = 1'b1; o.mode = M_DRAIN;
        end else if (((rdy >> s.cur) & 1) == 0) begin
          p = rr(oth, s.cur, n); o.has = (p >= 0); o.tgt = p; o.mode = M_DRAIN;
        end else if (ts_en) begin
          if (s.cnt == q - 1) begin
            p = rr(oth, s.cur, n);
            if (p >= 0) begin o.tgt = p; o.has = 1'b1; o.mode = M_DRAIN; end
            else o.cnt = 0;
          end else o.cnt = s.cnt + 1;
        end
      end
      M_DRAIN: begin
        if (s.has && ((rdy >> s.tgt) & 1) == 0) begin
          p = rr(oth, s.cur, n); o.has = (p >= 0); o.tgt = p;
        end
        if (dr) o.mode = o.has ? M_SWITCH : M_IDLE;
      end
      default: begin
        o.cur = s.tgt; o.last = s.tgt; o.cnt = 0; o.has = 1'b0; o.mode = M_RUN;
      end
    endcase
    return o;
  endfunction

  task automatic compare_all();
    check_val("tid0",   int'(tid0), m[0].cur);
    check_val("drain0", int'(drq0), int'(m[0].mode != M_RUN));
    check_val("sw0",    int'(sv0),  int'(m[0].mode == M_SWITCH));
    check_val("idle0",  int'(idl0), int'(m[0].mode == M_IDLE));
    check_val("tid1",   int'(tid1), m[1].cur);
    check_val("drain1", int'(drq1), int'(m[1].mode != M_RUN));
    check_val("sw1",    int'(sv1),  int'(m[1].mode == M_SWITCH));
    check_val("idle1",  int'(idl1), int'(m[1].mode == M_IDLE));
  endtask

  task automatic cycle();
    @(posedge clk);
    m[0] = step(m[0], 2, 4, int'(r0), rv0, int'(rt0), dr0);
    m[1] = step(m[1], 3, 5, int'(r1), rv1, int'(rt1), dr1);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_tid0"},  int'(tid0), 0);
    check_val({tag, "_drain0"}, int'(drq0), 1);
    check_val({tag, "_sw0"},   int'(sv0), 0);
    check_val({tag, "_idle0"}, int'(idl0), 1);
    check_val({tag, "_tid1"},  int'(tid1), 0);
    check_val({tag, "_sw1"},   int'(sv1), 0);
    check_val({tag, "_idle1"}, int'(idl1), 1);
  endtask

  // Called just after a falling edge: reset lands between clock edges
  task automatic reset_mid(input string tag);
    #2 rst = 1'b1;
    #1 check_reset_outs(tag);
    m[0] = reset_mdl(2);
    m[1] = reset_mdl(3);
    @(posedge clk);
    @(negedge clk);
    check_reset_outs({tag, "_held"});
    rst = 1'b0;
  endtask

  initial begin
    m[0] = reset_mdl(2);
    m[1] = reset_mdl(3);
    dr1 = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outs("por");
    rst = 1'b0;

    // Bring-up with only thread 0 ready
    r0 = 2'b01; dr0 = 1'b1;
    cycle();
    check_val("bringup_sw", int'(sv0), 1);
    check_val("bringup_idle", int'(idl0), 0);
    cycle();
    check_val("bringup_tid", int'(tid0), 0);
    check_val("bringup_run", int'(drq0), 0);
    check_val("bringup_sw_once", int'(sv0), 0);

    // Out-of-range, self and non-ready requests are ignored
    rv0 = 1'b1;
    rt0 = 2'd3; cycle(); check_val("req_oor", int'(drq0), 0);
    rt0 = 2'd0; cycle(); check_val("req_self", int'(drq0), 0);
    rt0 = 2'd1; cycle(); check_val("req_notready", int'(drq0), 0);
    rv0 = 1'b0;

    // Ready-drop with nobody else ready, then wake on thread 1
    r0 = 2'b00;
    cycle(); check_val("drop_drain", int'(drq0), 1); check_val("drop_notidle", int'(idl0), 0);
    cycle(); check_val("drop_idle", int'(idl0), 1);
    r0 = 2'b10;
    cycle(); check_val("wake_sw", int'(sv0), 1);
    cycle(); check_val("wake_tid", int'(tid0), 1); check_val("wake_run", int'(drq0), 0);

    // CSR switch back to thread 0
    r0 = 2'b11; rv0 = 1'b1; rt0 = 2'd0;
    cycle(); rv0 = 1'b0; check_val("csr0_drain", int'(drq0), 1);
    cycle(); check_val("csr0_sw", int'(sv0), 1);
    cycle(); check_val("csr0_tid", int'(tid0), 0);

    // CSR coinciding with quantum expiry; pipeline refuses to drain for a while
    repeat (3) begin cycle(); check_val("pre_exp_run", int'(drq0), 0); end
    rv0 = 1'b1; rt0 = 2'd1; dr0 = 1'b0;
    cycle(); rv0 = 1'b0;
    check_val("csrq_drain", int'(drq0), 1);
    repeat (5) begin
      cycle();
      check_val("stall_tid", int'(tid0), 0);
      check_val("stall_drain", int'(drq0), 1);
    end
    dr0 = 1'b1;
    cycle(); check_val("csrq_sw", int'(sv0), 1); check_val("csrq_tid_hold", int'(tid0), 0);
    cycle(); check_val("csrq_tid", int'(tid0), 1);

    // Timeslice rotation: four RUN cycles, DRAIN, SWITCH, repeat
    for (int k = 1; k <= 12; k++) begin
      cycle();
`ifdef BP_BE_SCHED_TIMESLICE_EN
      check_val("q_tid", int'(tid0), (1 + k / 6) % 2);
      check_val("q_drain", int'(drq0), int'((k % 6) >= 4));
      check_val("q_sw", int'(sv0), int'((k % 6) == 5));
`else
      check_val("noq_tid", int'(tid0), 1);
      check_val("noq_drain", int'(drq0), 0);
`endif
    end

    // Reset in the middle of a drain, then in the middle of a switch
    rv0 = 1'b1; rt0 = 2'd0; dr0 = 1'b0;
    cycle(); rv0 = 1'b0;
    check_val("pre_rst_drain", int'(drq0), 1);
    reset_mid("rst_drain");
    r0 = 2'b01; dr0 = 1'b1;
    cycle(); check_val("pre_rst_sw", int'(sv0), 1);
    reset_mid("rst_switch");

    // Randomised traffic on both configurations
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) r0 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) r1 = 3'($urandom_range(0, 7));
      rv0 = ($urandom_range(0, 4) == 0);
      rt0 = 2'($urandom_range(0, 3));
      dr0 = ($urandom_range(0, 2) != 0);
      rv1 = ($urandom_range(0, 4) == 0);
      rt1 = 3'($urandom_range(0, 7));
      dr1 = ($urandom_range(0, 2) != 0);
      cycle();
      if ($urandom_range(0, 299) == 0) reset_mid("rst_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
